// File: rtl/hazard_interlock_unit_pkg.sv
// Shared encodings for the SimpleRisc hazard interlock unit.
// Latency classes and forwarding selects used by the unit and its users.
package hazard_interlock_unit_pkg;

  localparam logic [1:0] LAT_SINGLE = 2'd0;
  localparam logic [1:0] LAT_MUL    = 2'd1;
  localparam logic [1:0] LAT_DIV    = 2'd2;
  localparam logic [1:0] LAT_RSVD   = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_MA = 2'd2;
  localparam logic [1:0] FWD_RW = 2'd3;

endpackage

// File: rtl/hazard_interlock_unit_if.sv
// OF-stage decode info in, pipeline control and forwarding selects out.
// master: pipeline side; slave: interlock unit side.
interface hazard_interlock_unit_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 4
);

  logic            of_valid;
  logic [RA_W-1:0] of_rs1;
  logic            of_rs1_en;
  logic [RA_W-1:0] of_rs2;
  logic            of_rs2_en;
  logic [RA_W-1:0] of_rd;
  logic            of_wb;
  logic            of_ld;
  logic [1:0]      of_lat;
  logic            ex_branch_taken;

  logic             stall_if;
  logic             stall_of;
  logic             flush_of;
  logic             bubble_ex;
  logic             ex_hold;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] busy_cnt;

  modport master (
    output of_valid, of_rs1, of_rs1_en,
    output of_rs2, of_rs2_en, of_rd,
    output of_wb, of_ld, of_lat,
    output ex_branch_taken,
    input  stall_if, stall_of, flush_of,
    input  bubble_ex, ex_hold,
    input  fwd_a, fwd_b, busy_cnt
  );

  modport slave (
    input  of_valid, of_rs1, of_rs1_en,
    input  of_rs2, of_rs2_en, of_rd,
    input  of_wb, of_ld, of_lat,
    input  ex_branch_taken,
    output stall_if, stall_of, flush_of,
    output bubble_ex, ex_hold,
    output fwd_a, fwd_b, busy_cnt
  );

endinterface

// File: rtl/hazard_interlock_unit_busy.sv
// mc_busy_counter: extra-EX-cycle counter for multi-cycle ops.
// Loads on issue of MUL/DIV, then counts down; hold while nonzero.
module mc_busy_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_hold
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_hold = (r_cnt != '0);

endmodule

// File: rtl/hazard_interlock_unit.sv
// Interlock/forwarding controller with EX/MA/RW shadow scoreboard.
// Define HAZARD_PERF_EN to add stall/load-use/flush perf counters.
module hazard_interlock_unit
  import hazard_interlock_unit_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RA_W     = 4,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_interlock_unit_if.slave  bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_lu_count,
  output logic [31:0]             perf_flush_count
`endif
);

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            wb;
    logic            ld;
  } shadow_t;

  function automatic logic hit(
    input shadow_t         e,
    input logic [RA_W-1:0] s
  );
    return e.v & e.wb & (e.rd == s);
  endfunction

  // EX hits on a load fall through: load-use stalls that case.
  function automatic logic [1:0] fwd_sel(
    input logic            en,
    input logic [RA_W-1:0] s,
    input shadow_t         ex,
    input shadow_t         ma,
    input shadow_t         rw
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (en) begin
      if (hit(ex, s) && !ex.ld) sel = FWD_EX;
      else if (hit(ma, s))      sel = FWD_MA;
      else if (hit(rw, s))      sel = FWD_RW;
    end
    return sel;
  endfunction

  shadow_t r_ex, r_ma, r_rw;

  logic             w_hold;
  logic             w_lu;
  logic             w_issue;
  logic             w_load;
  logic [CNT_W-1:0] w_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_sel_flush;
  logic             w_sel_hold;
  logic             w_sel_lu;

  assign w_lu = bus.of_valid & r_ex.ld &
    ((bus.of_rs1_en & hit(r_ex, bus.of_rs1)) |
     (bus.of_rs2_en & hit(r_ex, bus.of_rs2)));

  assign w_issue = bus.of_valid & ~w_lu &
                   ~w_hold & ~bus.ex_branch_taken;

  assign w_sel_flush = bus.ex_branch_taken;
  assign w_sel_hold  = w_hold & ~w_sel_flush;
  assign w_sel_lu    = w_lu & ~w_hold & ~w_sel_flush;

  always_comb begin
    w_load = 1'b0;
    w_val  = '0;
    unique case (bus.of_lat)
      LAT_MUL: begin
        w_load = w_issue;
        w_val  = CNT_W'(MUL_LAT - 1);
      end
      LAT_DIV: begin
        w_load = w_issue;
        w_val  = CNT_W'(DIV_LAT - 1);
      end
      LAT_SINGLE, LAT_RSVD: ;
    endcase
  end

  mc_busy_counter #(.CNT_W(CNT_W)) u_busy (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_val  (w_val),
    .o_cnt  (w_cnt),
    .o_hold (w_hold)
  );

  // Outputs forced quiet while reset is high.
  always_comb begin
    bus.stall_if  = 1'b0;
    bus.stall_of  = 1'b0;
    bus.flush_of  = 1'b0;
    bus.bubble_ex = 1'b0;
    bus.ex_hold   = 1'b0;
    bus.fwd_a     = FWD_RF;
    bus.fwd_b     = FWD_RF;
    bus.busy_cnt  = '0;
    if (!reset) begin
      bus.ex_hold  = w_hold;
      bus.busy_cnt = w_cnt;
      bus.fwd_a = fwd_sel(bus.of_rs1_en, bus.of_rs1,
                          r_ex, r_ma, r_rw);
      bus.fwd_b = fwd_sel(bus.of_rs2_en, bus.of_rs2,
                          r_ex, r_ma, r_rw);
      unique case (1'b1)
        w_sel_flush: begin
          bus.flush_of  = 1'b1;
          bus.bubble_ex = 1'b1;
        end
        w_sel_hold: begin
          bus.stall_if = 1'b1;
          bus.stall_of = 1'b1;
        end
        w_sel_lu: begin
          bus.stall_if  = 1'b1;
          bus.stall_of  = 1'b1;
          bus.bubble_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex <= '0;
      r_ma <= '0;
      r_rw <= '0;
    end else begin
      if (w_hold) begin
        r_ma <= '0;
      end else begin
        r_ex <= w_issue ? {1'b1, bus.of_rd, bus.of_wb, bus.of_ld}
                        : '0;
        r_ma <= r_ex;
      end
      r_rw <= r_ma;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_lu_count     <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (bus.stall_if) perf_stall_cycles <= perf_stall_cycles + 1;
      if (w_sel_lu)     perf_lu_count     <= perf_lu_count + 1;
      if (bus.flush_of) perf_flush_count  <= perf_flush_count + 1;
    end
  end
`endif

  a_no_branch_in_hold: assert property (
    @(posedge clk) disable iff (reset)
    !(bus.ex_branch_taken && w_hold));

  a_rd_in_range: assert property (
    @(posedge clk) disable iff (reset)
    !(bus.of_valid && bus.of_wb) || (32'(bus.of_rd) < NUM_REGS));

endmodule

// File: tb/tb_hazard_interlock_unit.sv
// Directed-vector bench for hazard_interlock_unit.
// Inputs change 1ns after posedge; outputs sampled 2ns after posedge.
module tb_hazard_interlock_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_interlock_unit_if #(.RA_W(4), .CNT_W(4)) bus ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_lu_count;
  logic [31:0] perf_flush_count;
`endif

  hazard_interlock_unit #(
    .NUM_REGS (16),
    .RA_W     (4),
    .MUL_LAT  (3),
    .DIV_LAT  (8),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_lu_count     (perf_lu_count),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_if, stall_of, flush_of, bubble_ex, ex_hold}
  logic [4:0] ctl;
  assign ctl = {bus.stall_if, bus.stall_of, bus.flush_of,
                bus.bubble_ex, bus.ex_hold};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_of(
    input logic       v,
    input logic [3:0] rs1, input logic e1,
    input logic [3:0] rs2, input logic e2,
    input logic [3:0] rd,  input logic wb,
    input logic       ld,  input logic [1:0] lat
  );
    bus.of_valid  = v;
    bus.of_rs1    = rs1;
    bus.of_rs1_en = e1;
    bus.of_rs2    = rs2;
    bus.of_rs2_en = e2;
    bus.of_rd     = rd;
    bus.of_wb     = wb;
    bus.of_ld     = ld;
    bus.of_lat    = lat;
  endtask

  task automatic nop();
    set_of(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clean();
    nop();
    bus.ex_branch_taken = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_of(1, 1, 1, 2, 1, 3, 1, 1, 1);
    bus.ex_branch_taken = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if (ctl !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b0);
    end
    total++;
    if ({bus.fwd_a, bus.fwd_b, bus.busy_cnt} !== 8'h0) begin
      bad++;
      $display("FAIL reset_fwd_busy got=%h exp=00",
               {bus.fwd_a, bus.fwd_b, bus.busy_cnt});
    end
    bus.ex_branch_taken = 1'b0;
    nop();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_forward_ex();
    clean();
    set_of(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    set_of(1, 1, 1, 2, 1, 5, 1, 0, 0);
    #1;
    total++;
    if (bus.fwd_a !== 2'd1 || bus.fwd_b !== 2'd0) begin
      bad++;
      $display("FAIL fwd_ex got=%0d/%0d exp=1/0",
               bus.fwd_a, bus.fwd_b);
    end
    total++;
    if (ctl !== 5'b0) begin
      bad++;
      $display("FAIL fwd_ex_ctl got=%b exp=00000", ctl);
    end
    bus.of_rs1_en = 1'b0;
    #1;
    total++;
    if (bus.fwd_a !== 2'd0) begin
      bad++;
      $display("FAIL fwd_disabled got=%0d exp=0", bus.fwd_a);
    end
    nop();
  endtask

  task automatic test_load_use();
    clean();
    set_of(1, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    set_of(1, 4, 1, 2, 1, 6, 1, 0, 0);
    #1;
    total++;
    if (ctl !== 5'b11010) begin
      bad++;
      $display("FAIL lu_stall got=%b exp=11010", ctl);
    end
    tick();
    #1;
    total++;
    if (ctl !== 5'b0 || bus.fwd_b !== 2'd2 || bus.fwd_a !== 2'd0) begin
      bad++;
      $display("FAIL lu_after got=%b/%0d/%0d exp=00000/0/2",
               ctl, bus.fwd_a, bus.fwd_b);
    end
    nop();
  endtask

  task automatic test_multicycle();
    clean();
    set_of(1, 0, 0, 0, 0, 7, 1, 0, 1);
    tick();
    set_of(1, 7, 1, 0, 0, 8, 1, 0, 0);
    #1;
    total++;
    if (bus.busy_cnt !== 4'd2 || ctl !== 5'b11001 || bus.fwd_a !== 2'd1) begin
      bad++;
      $display("FAIL mul_c1 got=%0d/%b/%0d exp=2/11001/1",
               bus.busy_cnt, ctl, bus.fwd_a);
    end
    tick();
    #1;
    total++;
    if (bus.busy_cnt !== 4'd1 || ctl !== 5'b11001) begin
      bad++;
      $display("FAIL mul_c2 got=%0d/%b exp=1/11001",
               bus.busy_cnt, ctl);
    end
    tick();
    #1;
    total++;
    if (bus.busy_cnt !== 4'd0 || ctl !== 5'b0 || bus.fwd_a !== 2'd1) begin
      bad++;
      $display("FAIL mul_done got=%0d/%b/%0d exp=0/00000/1",
               bus.busy_cnt, ctl, bus.fwd_a);
    end
    clean();
    set_of(1, 0, 0, 0, 0, 9, 1, 0, 2);
    tick();
    nop();
    for (int k = 7; k >= 1; k--) begin
      #1;
      total++;
      if (bus.busy_cnt !== 4'(k) || bus.ex_hold !== 1'b1) begin
        bad++;
        $display("FAIL div_hold got=%0d/%b exp=%0d/1",
                 bus.busy_cnt, bus.ex_hold, k);
      end
      tick();
    end
    #1;
    total++;
    if (bus.busy_cnt !== 4'd0 || bus.ex_hold !== 1'b0) begin
      bad++;
      $display("FAIL div_done got=%0d/%b exp=0/0",
               bus.busy_cnt, bus.ex_hold);
    end
  endtask

  task automatic test_flush();
    clean();
    set_of(1, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    set_of(1, 0, 0, 2, 1, 6, 1, 0, 0);
    bus.ex_branch_taken = 1'b1;
    #1;
    total++;
    if (ctl !== 5'b00110) begin
      bad++;
      $display("FAIL flush_ctl got=%b exp=00110", ctl);
    end
    tick();
    bus.ex_branch_taken = 1'b0;
    set_of(1, 2, 1, 0, 0, 6, 1, 0, 0);
    #1;
    total++;
    if (ctl !== 5'b0 || bus.fwd_a !== 2'd2) begin
      bad++;
      $display("FAIL flush_after got=%b/%0d exp=00000/2",
               ctl, bus.fwd_a);
    end
    nop();
  endtask

  task automatic test_priority();
    clean();
    set_of(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    nop();
    tick();
    set_of(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    set_of(1, 3, 1, 3, 0, 4, 0, 0, 0);
    #1;
    total++;
    if (bus.fwd_a !== 2'd1 || bus.fwd_b !== 2'd0) begin
      bad++;
      $display("FAIL prio_ex got=%0d/%0d exp=1/0",
               bus.fwd_a, bus.fwd_b);
    end
    bus.of_valid = 1'b0;
    tick();
    #1;
    total++;
    if (bus.fwd_a !== 2'd2) begin
      bad++;
      $display("FAIL prio_ma got=%0d exp=2", bus.fwd_a);
    end
    tick();
    #1;
    total++;
    if (bus.fwd_a !== 2'd3) begin
      bad++;
      $display("FAIL prio_rw got=%0d exp=3", bus.fwd_a);
    end
    nop();
  endtask

  task automatic test_back_to_back();
    clean();
    set_of(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    set_of(1, 0, 0, 0, 0, 6, 1, 0, 0);
    tick();
    set_of(1, 5, 1, 6, 1, 7, 1, 0, 0);
    #1;
    total++;
    if (bus.fwd_a !== 2'd2 || bus.fwd_b !== 2'd1 || ctl !== 5'b0) begin
      bad++;
      $display("FAIL b2b got=%0d/%0d/%b exp=2/1/00000",
               bus.fwd_a, bus.fwd_b, ctl);
    end
    nop();
  endtask

  task automatic test_reset_mid_div();
    clean();
    set_of(1, 0, 0, 0, 0, 9, 1, 0, 2);
    tick();
    nop();
    tick();
    tick();
    #1;
    total++;
    if (bus.busy_cnt !== 4'd5) begin
      bad++;
      $display("FAIL rst_div_pre got=%0d exp=5", bus.busy_cnt);
    end
    reset = 1'b1;
    set_of(1, 9, 1, 9, 1, 1, 1, 0, 0);
    #1;
    total++;
    if (ctl !== 5'b0 || bus.busy_cnt !== 4'd0 || bus.fwd_a !== 2'd0) begin
      bad++;
      $display("FAIL rst_div_during got=%b/%0d/%0d exp=00000/0/0",
               ctl, bus.busy_cnt, bus.fwd_a);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (bus.busy_cnt !== 4'd0 || ctl !== 5'b0 ||
        bus.fwd_a !== 2'd0 || bus.fwd_b !== 2'd0) begin
      bad++;
      $display("FAIL rst_div_after got=%0d/%b/%0d/%0d exp=0/00000/0/0",
               bus.busy_cnt, ctl, bus.fwd_a, bus.fwd_b);
    end
    nop();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.ex_branch_taken = 1'b0;
    nop();
    test_reset();
    test_forward_ex();
    test_load_use();
    test_multicycle();
    test_flush();
    test_priority();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
